alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered RV32I decode stage that turns a fetched instruction into the ALU control word (`alu_ctl`, `sub`, `sign`), operand selects, immediate and register/memory enables for the execute stage. It sits between instruction fetch and the ALU. Upstream and downstream both use valid/ready handshakes, and a flush input supports branch redirects. The `alu_ctl` encodings are shared with the ALU through the common package.

## Interface
Parameters:
- `XLEN`, 32, datapath width. Only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  32  PC of `in_inst`.
- `flush`  in  1  discard the held output and any instruction accepted this cycle.
- `out_valid`  out  1  decoded bundle is valid.
- `out_ready`  in  1  execute stage accepts the bundle.
- `out_pc`  out  32  registered PC.
- `alu_ctl`  out  4  ALU operation code (package encoding).
- `sub`, `sign`  out  1 each  ALU subtract and signed-compare controls.
- `a_sel`  out  2  operand A source: 0=RS1, 1=PC, 2=ZERO.
- `b_sel`  out  2  operand B source: 0=RS2, 1=IMM, 2=FOUR.
- `imm`  out  32  sign-extended immediate.
- `rs1`, `rs2`, `rd`  out  5 each  register indices.
- `reg_we`, `mem_re`, `mem_we`, `is_branch`, `is_jal`, `is_jalr`, `illegal`  out  1 each  control flags.

## Operation
- **ALU codes:** ADD=0000, XOR=0001, OR=0010, AND=0011, SLL=0100, SRL=0101, SRA=0110, BEQ=1000, BNE=1001, BLT=1010, BGE=1011, SET=1100.
- **LUI:** ADD, a=ZERO, b=IMM, U-imm.
- **AUIPC:** ADD, a=PC, b=IMM, U-imm.
- **JAL:** ADD, a=PC, b=FOUR, J-imm, `is_jal`.
- **JALR** (funct3 must be 000): ADD, a=PC, b=FOUR, I-imm, `is_jalr`.
- **BRANCH:** a=RS1, b=RS2, B-imm, `sub`=1, `is_branch`, `reg_we`=0.
  - funct3 000 → BEQ; 001 → BNE.
  - 100 → BLT, sign=1; 101 → BGE, sign=1.
  - 110 → BLT, sign=0; 111 → BGE, sign=0.
  - 010 and 011 → illegal.
- **LOAD:** ADD, RS1+I-imm, `mem_re`, `reg_we`.
- **STORE:** ADD, RS1+S-imm, `mem_we`, `reg_we`=0.
- **OP-IMM and OP:**
  - funct3 000 → ADD. For OP only, funct7=0100000 sets `sub`=1.
  - 010 → SET, sub=1, sign=1; 011 → SET, sub=1, sign=0.
  - 100 → XOR; 110 → OR; 111 → AND.
  - 001 → SLL.
  - 101 → SRL if inst[30]=0, SRA if inst[30]=1.
  - OP-IMM uses b=IMM with I-imm; OP uses b=RS2.
  - funct7 must be 0000000. The only exception is 0100000 for SUB/SRA (and SRAI); any other funct7 is illegal.
- **Illegal encodings** (any other opcode, or a bad funct field) produce `illegal`=1, ADD, and `reg_we`/`mem_re`/`mem_we`/branch/jump flags all 0. The bundle still passes downstream as valid.
- `reg_we` is forced to 0 when rd=0.
- **Immediates:** I, S, B, U and J formats per the RV32I spec, with sign extension from inst[31]. B and J immediates have bit0 = 0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- `in_ready = !out_valid || out_ready` (combinational). There is no skid buffer.
- A transfer happens on an edge where `in_valid && in_ready` (input side) or `out_valid && out_ready` (output side).
- While `out_valid && !out_ready`, all outputs hold stable.
- `flush` is synchronous. At the next edge `out_valid` becomes 0, and any input accepted in that cycle is dropped.
- `flush` has priority over a simultaneous accept.
- Reset (asynchronous, any time, including mid-stall) forces:
  - `out_valid`=0;
  - all control flags = 0;
  - `alu_ctl`=0000, `a_sel`=`b_sel`=0;
  - `imm`, `out_pc`, `rs1`, `rs2`, `rd` = 0.
- Data registers load only on an accept, so there is no toggling while idle.

## Structure
- **Shared package:** `alu_ctl` localparam values, `a_sel`/`b_sel` encodings, RV32I opcode constants.
- **One sub-module:** `imm_gen`, a combinational block mapping inst to the 32-bit immediate for each format.
- **Top module:** decode logic, pipeline register and handshake.

## Test plan
- `in_inst`=0x002081B3 (add x3,x1,x2) → next cycle `alu_ctl`=0000, sub=0, a_sel=0, b_sel=0, rd=3, reg_we=1.
- `in_inst`=0x402081B3 (sub) → sub=1, alu_ctl=0000. Then 0x0020E063 (bltu x1,x2,0) → alu_ctl=1010, sub=1, sign=0, is_branch=1, reg_we=0, imm=0.
- `in_inst`=0x40335293 (srai x5,x6,3) → alu_ctl=0110, b_sel=1, imm=0x403. Then the same word with funct7=0100001 → illegal=1, reg_we=0.
- **Backpressure:** hold `out_ready`=0 with two instructions offered back to back → first held stable, `in_ready`=0. Release → second is accepted the next cycle, nothing lost or duplicated.
- **Flush:** assert `flush` with `in_valid`=1 and `out_valid`=1 → next cycle `out_valid`=0 and the input is dropped.
- **Reset:** assert `rst` mid-stall → `out_valid`=0 and all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage and the ALU.
// Holds ALU op codes, operand selects, opcodes and the decoded bundle layout.
package alu_decode_stage_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_XOR = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_BEQ = 4'b1000;
    localparam logic [3:0] ALU_BNE = 4'b1001;
    localparam logic [3:0] ALU_BLT = 4'b1010;
    localparam logic [3:0] ALU_BGE = 4'b1011;
    localparam logic [3:0] ALU_SET = 4'b1100;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [3:0]         alu_ctl;
        logic               sub;
        logic               sign;
        logic [1:0]         a_sel;
        logic [1:0]         b_sel;
        logic [RV_XLEN-1:0] imm;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               reg_we;
        logic               mem_re;
        logic               mem_we;
        logic               is_branch;
        logic               is_jal;
        logic               is_jalr;
        logic               illegal;
        logic [RV_XLEN-1:0] pc;
    } dec_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// The slave modport is the decode stage; master is its environment.
interface alu_decode_stage_if;
    import alu_decode_stage_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [RV_XLEN-1:0] in_inst;
    logic [RV_XLEN-1:0] in_pc;
    logic               flush;

    logic               out_valid;
    logic               out_ready;
    logic [RV_XLEN-1:0] out_pc;
    logic [3:0]         alu_ctl;
    logic               sub;
    logic               sign;
    logic [1:0]         a_sel;
    logic [1:0]         b_sel;
    logic [RV_XLEN-1:0] imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               reg_we;
    logic               mem_re;
    logic               mem_we;
    logic               is_branch;
    logic               is_jal;
    logic               is_jalr;
    logic               illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, alu_ctl, sub, sign, a_sel, b_sel,
               imm, rs1, rs2, rd, reg_we, mem_re, mem_we, is_branch, is_jal,
               is_jalr, illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, alu_ctl, sub, sign, a_sel, b_sel,
               imm, rs1, rs2, rd, reg_we, mem_re, mem_we, is_branch, is_jal,
               is_jalr, illegal
    );

endinterface

// File: rtl/alu_decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; the opcode bits are not needed,
// so only inst[31:7] is taken. Unused formats yield zero.
module alu_decode_stage_imm_gen
    import alu_decode_stage_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic [31:7]     inst_hi,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{inst_hi[31]}}, inst_hi[31:20]};
            IMM_S: imm = {{20{inst_hi[31]}}, inst_hi[31:25], inst_hi[11:7]};
            IMM_B: imm = {{19{inst_hi[31]}}, inst_hi[31], inst_hi[7],
                          inst_hi[30:25], inst_hi[11:8], 1'b0};
            IMM_U: imm = {inst_hi[31:12], 12'b0};
            IMM_J: imm = {{11{inst_hi[31]}}, inst_hi[31], inst_hi[19:12],
                          inst_hi[20], inst_hi[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage: instruction in, ALU control bundle out,
// one cycle of latency with valid/ready on both sides and a synchronous flush.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic               clk,
    input  logic               rst,
    alu_decode_stage_if.slave  bus
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_field;

    dec_t            ctl_next;
    dec_t            dec_next;
    dec_t            dec_reg;
    imm_fmt_e        fmt_next;
    logic            legal;
    logic            is_op;
    logic            alt_ok;
    logic [XLEN-1:0] imm_w;
    logic            out_valid_reg;
    logic            accept;

    assign opcode   = bus.in_inst[6:0];
    assign rd_field = bus.in_inst[11:7];
    assign funct3   = bus.in_inst[14:12];
    assign funct7   = bus.in_inst[31:25];

    alu_decode_stage_imm_gen #(.XLEN(XLEN)) imm_gen (
        .inst_hi (bus.in_inst[31:7]),
        .fmt     (fmt_next),
        .imm     (imm_w)
    );

    always_comb begin
        ctl_next     = '0;
        ctl_next.pc  = bus.in_pc;
        ctl_next.rs1 = bus.in_inst[19:15];
        ctl_next.rs2 = bus.in_inst[24:20];
        ctl_next.rd  = rd_field;
        fmt_next     = IMM_NONE;
        legal        = 1'b1;
        is_op        = 1'b0;
        alt_ok       = 1'b0;

        case (opcode)
            OPC_LUI: begin
                ctl_next.a_sel  = A_ZERO;
                ctl_next.b_sel  = B_IMM;
                ctl_next.reg_we = 1'b1;
                fmt_next        = IMM_U;
            end
            OPC_AUIPC: begin
                ctl_next.a_sel  = A_PC;
                ctl_next.b_sel  = B_IMM;
                ctl_next.reg_we = 1'b1;
                fmt_next        = IMM_U;
            end
            OPC_JAL: begin
                ctl_next.a_sel  = A_PC;
                ctl_next.b_sel  = B_FOUR;
                ctl_next.reg_we = 1'b1;
                ctl_next.is_jal = 1'b1;
                fmt_next        = IMM_J;
            end
            OPC_JALR: begin
                ctl_next.a_sel   = A_PC;
                ctl_next.b_sel   = B_FOUR;
                ctl_next.reg_we  = 1'b1;
                ctl_next.is_jalr = 1'b1;
                fmt_next         = IMM_I;
                legal            = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                ctl_next.sub       = 1'b1;
                ctl_next.is_branch = 1'b1;
                fmt_next           = IMM_B;
                case (funct3)
                    3'b000: ctl_next.alu_ctl = ALU_BEQ;
                    3'b001: ctl_next.alu_ctl = ALU_BNE;
                    3'b100: begin ctl_next.alu_ctl = ALU_BLT; ctl_next.sign = 1'b1; end
                    3'b101: begin ctl_next.alu_ctl = ALU_BGE; ctl_next.sign = 1'b1; end
                    3'b110: ctl_next.alu_ctl = ALU_BLT;
                    3'b111: ctl_next.alu_ctl = ALU_BGE;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                ctl_next.b_sel  = B_IMM;
                ctl_next.reg_we = 1'b1;
                ctl_next.mem_re = 1'b1;
                fmt_next        = IMM_I;
            end
            OPC_STORE: begin
                ctl_next.b_sel  = B_IMM;
                ctl_next.mem_we = 1'b1;
                fmt_next        = IMM_S;
            end
            OPC_OP_IMM, OPC_OP: begin
                is_op           = (opcode == OPC_OP);
                ctl_next.b_sel  = is_op ? B_RS2 : B_IMM;
                ctl_next.reg_we = 1'b1;
                fmt_next        = is_op ? IMM_NONE : IMM_I;
                case (funct3)
                    3'b000: begin
                        ctl_next.alu_ctl = ALU_ADD;
                        ctl_next.sub     = is_op && (funct7 == F7_ALT);
                    end
                    3'b010: begin
                        ctl_next.alu_ctl = ALU_SET;
                        ctl_next.sub     = 1'b1;
                        ctl_next.sign    = 1'b1;
                    end
                    3'b011: begin
                        ctl_next.alu_ctl = ALU_SET;
                        ctl_next.sub     = 1'b1;
                    end
                    3'b100: ctl_next.alu_ctl = ALU_XOR;
                    3'b110: ctl_next.alu_ctl = ALU_OR;
                    3'b111: ctl_next.alu_ctl = ALU_AND;
                    3'b001: ctl_next.alu_ctl = ALU_SLL;
                    default: ctl_next.alu_ctl = funct7[5] ? ALU_SRA : ALU_SRL;
                endcase
                // In OP-IMM the upper bits are immediate except for shifts.
                if (is_op || funct3 == 3'b001 || funct3 == 3'b101) begin
                    alt_ok = (funct3 == 3'b101) || (is_op && funct3 == 3'b000);
                    if (!(funct7 == F7_BASE || (funct7 == F7_ALT && alt_ok)))
                        legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            ctl_next.alu_ctl   = ALU_ADD;
            ctl_next.sub       = 1'b0;
            ctl_next.sign      = 1'b0;
            ctl_next.a_sel     = A_RS1;
            ctl_next.b_sel     = B_RS2;
            ctl_next.reg_we    = 1'b0;
            ctl_next.mem_re    = 1'b0;
            ctl_next.mem_we    = 1'b0;
            ctl_next.is_branch = 1'b0;
            ctl_next.is_jal    = 1'b0;
            ctl_next.is_jalr   = 1'b0;
            ctl_next.illegal   = 1'b1;
            fmt_next           = IMM_NONE;
        end

        if (rd_field == 5'd0)
            ctl_next.reg_we = 1'b0;
    end

    // Immediate merged in a separate block so the format select does not loop back.
    always_comb begin
        dec_next     = ctl_next;
        dec_next.imm = imm_w;
    end

    assign bus.in_ready = !out_valid_reg || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            dec_reg       <= '0;
        end else begin
            if (bus.flush)
                out_valid_reg <= 1'b0;
            else if (accept)
                out_valid_reg <= 1'b1;
            else if (bus.out_ready)
                out_valid_reg <= 1'b0;

            if (accept && !bus.flush)
                dec_reg <= dec_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_pc    = dec_reg.pc;
    assign bus.alu_ctl   = dec_reg.alu_ctl;
    assign bus.sub       = dec_reg.sub;
    assign bus.sign      = dec_reg.sign;
    assign bus.a_sel     = dec_reg.a_sel;
    assign bus.b_sel     = dec_reg.b_sel;
    assign bus.imm       = dec_reg.imm;
    assign bus.rs1       = dec_reg.rs1;
    assign bus.rs2       = dec_reg.rs2;
    assign bus.rd        = dec_reg.rd;
    assign bus.reg_we    = dec_reg.reg_we;
    assign bus.mem_re    = dec_reg.mem_re;
    assign bus.mem_we    = dec_reg.mem_we;
    assign bus.is_branch = dec_reg.is_branch;
    assign bus.is_jal    = dec_reg.is_jal;
    assign bus.is_jalr   = dec_reg.is_jalr;
    assign bus.illegal   = dec_reg.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: hand-written expected decodes are
// queued on accept and compared while the bundle is presented downstream.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [3:0]  alu;
        logic        sub;
        logic        sign;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [31:0] imm;
        logic        imm_dc;
        logic [6:0]  fl;   // {reg_we, mem_re, mem_we, is_branch, is_jal, is_jalr, illegal}
    } tv_t;

    typedef struct packed {
        logic [31:0] pc;
        tv_t         tv;
    } exp_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    tv_t  tvs[$];
    exp_t q[$];

    alu_decode_stage_if bus ();

    alu_decode_stage #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic void add_tv(input logic [31:0] inst, input logic [3:0] alu,
                                   input logic sub, input logic sign,
                                   input logic [1:0] a, input logic [1:0] b,
                                   input logic [31:0] imm, input logic imm_dc,
                                   input logic [6:0] fl);
        tv_t t;
        t.inst = inst; t.alu = alu; t.sub = sub; t.sign = sign; t.a = a; t.b = b;
        t.imm = imm; t.imm_dc = imm_dc; t.fl = fl;
        tvs.push_back(t);
    endfunction

    task automatic compare_out(input exp_t e);
        logic [31:0] ins;
        ins = e.tv.inst;
        chk("out_pc",  bus.out_pc, e.pc);
        chk("alu_ctl", 32'(bus.alu_ctl), 32'(e.tv.alu));
        chk("sub",     32'(bus.sub), 32'(e.tv.sub));
        chk("sign",    32'(bus.sign), 32'(e.tv.sign));
        chk("a_sel",   32'(bus.a_sel), 32'(e.tv.a));
        chk("b_sel",   32'(bus.b_sel), 32'(e.tv.b));
        if (!e.tv.imm_dc) chk("imm", bus.imm, e.tv.imm);
        chk("rs1",     32'(bus.rs1), 32'(ins[19:15]));
        chk("rs2",     32'(bus.rs2), 32'(ins[24:20]));
        chk("rd",      32'(bus.rd), 32'(ins[11:7]));
        chk("flags",   32'({bus.reg_we, bus.mem_re, bus.mem_we, bus.is_branch,
                            bus.is_jal, bus.is_jalr, bus.illegal}), 32'(e.tv.fl));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ctl"}, 32'({bus.alu_ctl, bus.sub, bus.sign, bus.a_sel, bus.b_sel,
                                bus.reg_we, bus.mem_re, bus.mem_we, bus.is_branch,
                                bus.is_jal, bus.is_jalr, bus.illegal}), 32'd0);
        chk({tag, "_imm"}, bus.imm, 32'd0);
        chk({tag, "_pc"}, bus.out_pc, 32'd0);
        chk({tag, "_regs"}, 32'({bus.rs1, bus.rs2, bus.rd}), 32'd0);
    endtask

    // One cycle: drive at negedge, check 1ns later, update scoreboard for the coming edge.
    task automatic step(input logic v, input tv_t t, input logic [31:0] pc,
                        input logic ordy, input logic fl, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_inst   = t.inst;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || ordy));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (bus.out_valid && q.size() != 0) compare_out(q[0]);
        acc = v && bus.in_ready && !fl;
        if (q.size() != 0 && (fl || ordy)) begin
            if (!fl)
                $display("txn pc=%08h inst=%08h alu=%h rd=%0d ill=%0b",
                         bus.out_pc, q[0].tv.inst, bus.alu_ctl, bus.rd, bus.illegal);
            void'(q.pop_front());
        end
        if (acc) begin
            e.pc = pc;
            e.tv = t;
            q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] pc;
        int          idx;
        int          cyc;
        tv_t         idle_tv;

        add_tv(32'h002081B3, 4'h0, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b1000000); // add x3,x1,x2
        add_tv(32'h402081B3, 4'h0, 1, 0, 2'd0, 2'd0, 32'h0,        1, 7'b1000000); // sub
        add_tv(32'h0020E063, 4'hA, 1, 0, 2'd0, 2'd0, 32'h0,        0, 7'b0001000); // bltu
        add_tv(32'h40335293, 4'h6, 0, 0, 2'd0, 2'd1, 32'h403,      0, 7'b1000000); // srai
        add_tv(32'h42335293, 4'h0, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b0000001); // bad funct7
        add_tv(32'h123453B7, 4'h0, 0, 0, 2'd2, 2'd1, 32'h12345000, 0, 7'b1000000); // lui
        add_tv(32'hFFFFF097, 4'h0, 0, 0, 2'd1, 2'd1, 32'hFFFFF000, 0, 7'b1000000); // auipc
        add_tv(32'hFFDFF0EF, 4'h0, 0, 0, 2'd1, 2'd2, 32'hFFFFFFFC, 0, 7'b1000100); // jal -4
        add_tv(32'h00808067, 4'h0, 0, 0, 2'd1, 2'd2, 32'h8,        0, 7'b0000010); // jalr x0
        add_tv(32'h00809067, 4'h0, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b0000001); // jalr f3!=0
        add_tv(32'hFF812283, 4'h0, 0, 0, 2'd0, 2'd1, 32'hFFFFFFF8, 0, 7'b1100000); // lw
        add_tv(32'h0063A623, 4'h0, 0, 0, 2'd0, 2'd1, 32'hC,        0, 7'b0010000); // sw
        add_tv(32'h00208863, 4'h8, 1, 0, 2'd0, 2'd0, 32'h10,       0, 7'b0001000); // beq +16
        add_tv(32'hFE41DFE3, 4'hB, 1, 1, 2'd0, 2'd0, 32'hFFFFFFFE, 0, 7'b0001000); // bge -2
        add_tv(32'h0020A063, 4'h0, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b0000001); // branch f3=010
        add_tv(32'hFFF00513, 4'h0, 0, 0, 2'd0, 2'd1, 32'hFFFFFFFF, 0, 7'b1000000); // addi -1
        add_tv(32'h00563593, 4'hC, 1, 0, 2'd0, 2'd1, 32'h5,        0, 7'b1000000); // sltiu
        add_tv(32'h003120B3, 4'hC, 1, 1, 2'd0, 2'd0, 32'h0,        1, 7'b1000000); // slt
        add_tv(32'h007372B3, 4'h3, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b1000000); // and
        add_tv(32'h007352B3, 4'h5, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b1000000); // srl
        add_tv(32'h407352B3, 4'h6, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b1000000); // sra
        add_tv(32'h00335293, 4'h5, 0, 0, 2'd0, 2'd1, 32'h3,        0, 7'b1000000); // srli
        add_tv(32'h40331293, 4'h0, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b0000001); // slli bad funct7
        add_tv(32'h00208033, 4'h0, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b0000000); // add x0
        add_tv(32'h0000007F, 4'h0, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b0000001); // bad opcode
        add_tv(32'h023160B3, 4'h0, 0, 0, 2'd0, 2'd0, 32'h0,        1, 7'b0000001); // funct7=0000001
        add_tv(32'hFFF14093, 4'h1, 0, 0, 2'd0, 2'd1, 32'hFFFFFFFF, 0, 7'b1000000); // xori -1

        idle_tv = '0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        rst = 1'b1;
        #2;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Random valid/ready traffic through the whole table.
        pc  = 32'h0000_1000;
        idx = 0;
        cyc = 0;
        while (idx < tvs.size() && cyc < 3000) begin
            step(($urandom_range(0, 3) != 0), tvs[idx], pc, ($urandom_range(0, 3) != 0), 1'b0, acc);
            if (acc) begin
                idx++;
                pc += 4;
            end
            cyc++;
        end
        if (idx < tvs.size()) chk("run_timeout", 32'(idx), 32'(tvs.size()));
        repeat (2) step(1'b0, idle_tv, 32'h0, 1'b1, 1'b0, acc);

        // Backpressure: first held, second waits, then both pass exactly once.
        step(1'b1, tvs[0], 32'h2000, 1'b0, 1'b0, acc);
        chk("bp_acc_first", 32'(acc), 32'd1);
        step(1'b1, tvs[1], 32'h2004, 1'b0, 1'b0, acc);
        chk("bp_blocked", 32'(acc), 32'd0);
        step(1'b1, tvs[1], 32'h2004, 1'b0, 1'b0, acc);
        chk("bp_still_blocked", 32'(acc), 32'd0);
        step(1'b1, tvs[1], 32'h2004, 1'b1, 1'b0, acc);
        chk("bp_release_acc", 32'(acc), 32'd1);
        step(1'b0, idle_tv, 32'h0, 1'b1, 1'b0, acc);
        step(1'b0, idle_tv, 32'h0, 1'b1, 1'b0, acc);

        // Flush with a held bundle and a new input: both discarded.
        step(1'b1, tvs[2], 32'h3000, 1'b0, 1'b0, acc);
        step(1'b1, tvs[3], 32'h3004, 1'b0, 1'b1, acc);
        step(1'b0, idle_tv, 32'h0, 1'b1, 1'b0, acc);
        chk("flush_cleared", 32'(bus.out_valid), 32'd0);
        step(1'b0, idle_tv, 32'h0, 1'b1, 1'b0, acc);

        // Asynchronous reset in the middle of a stall.
        step(1'b1, tvs[5], 32'h4000, 1'b0, 1'b0, acc);
        step(1'b1, tvs[6], 32'h4004, 1'b0, 1'b0, acc);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, idle_tv, 32'h0, 1'b1, 1'b0, acc);
        step(1'b1, tvs[7], 32'h5000, 1'b1, 1'b0, acc);
        step(1'b0, idle_tv, 32'h0, 1'b1, 1'b0, acc);
        step(1'b0, idle_tv, 32'h0, 1'b1, 1'b0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
